// File: rtl/difftest_commit_serializer.sv
// difftest_commit_serializer
// Compacts the per-lane commit stream into a circular FIFO and drains one
// retirement per cycle over a valid/ready trace port. Each entry carries a
// sequence number. The commit stage never stalls. When there is not room for
// a whole cycle's packet, the packet is dropped and the drop is recorded in
// sticky status.
//
// Handshake: out_valid is high while the FIFO holds an entry, and out_* shows
// the head entry. A transfer happens on a rising edge where out_valid &&
// out_ready. While out_valid && !out_ready, the out_* fields stay stable.
module difftest_commit_serializer #(
  parameter int CONFIG_DW             = 32,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_FIFO_DEPTH   = 3,
  parameter int PC_W                  = 30,
  parameter int INSN_DW               = 32,
  parameter int LRF_AW                = 5
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            trace_clr,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]           cmt_valid,
  input  logic [PC_W*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]      cmt_pc,
  input  logic [INSN_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]   cmt_insn,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]           cmt_wen,
  input  logic [LRF_AW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    cmt_wnum,
  input  logic [CONFIG_DW*(1<<CONFIG_P_COMMIT_WIDTH)-1:0] cmt_wdata,
  input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]           cmt_excp,
  input  logic [32*(1<<CONFIG_P_COMMIT_WIDTH)-1:0]        cmt_excp_vect,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [PC_W-1:0]                                 out_pc,
  output logic [INSN_DW-1:0]                              out_insn,
  output logic                                            out_wen,
  output logic [LRF_AW-1:0]                               out_wnum,
  output logic [CONFIG_DW-1:0]                            out_wdata,
  output logic                                            out_excp,
  output logic [31:0]                                     out_excp_vect,
  output logic [31:0]                                     out_seq,
  output logic                                            overflow,
  output logic [15:0]                                     drop_cnt
);

  localparam int CW    = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int AW    = CONFIG_P_FIFO_DEPTH;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [INSN_DW-1:0]   insn;
    logic                 wen;
    logic [LRF_AW-1:0]    wnum;
    logic [CONFIG_DW-1:0] wdata;
    logic                 excp;
    logic [31:0]          excp_vect;
    logic [31:0]          seq;
  } entry_t;

  entry_t mem [DEPTH];

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      seq_cnt;

  logic [CNT_W-1:0] lane_off [CW];
  logic [AW-1:0]    wr_idx   [CW];
  entry_t           lane_ent [CW];
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] n_acc;
  logic [CNT_W-1:0] space;
  logic             accept;
  logic             drop;
  logic             pop;
  logic [16:0]      drop_sum;
  entry_t           head;

  // Give each valid lane its compacted slot (a prefix popcount) and build its entry
  always_comb begin
    n = '0;
    for (int i = 0; i < CW; i++) begin
      lane_off[i] = n;
      n           = n + CNT_W'(cmt_valid[i]);
      wr_idx[i]   = wptr + AW'(lane_off[i]);
      lane_ent[i].pc        = cmt_pc[i*PC_W +: PC_W];
      lane_ent[i].insn      = cmt_insn[i*INSN_DW +: INSN_DW];
      lane_ent[i].wen       = cmt_wen[i];
      lane_ent[i].wnum      = cmt_wnum[i*LRF_AW +: LRF_AW];
      lane_ent[i].wdata     = cmt_wdata[i*CONFIG_DW +: CONFIG_DW];
      lane_ent[i].excp      = cmt_excp[i];
      lane_ent[i].excp_vect = cmt_excp_vect[i*32 +: 32];
      lane_ent[i].seq       = seq_cnt + 32'(lane_off[i]);
    end
  end

  // Admission is all-or-nothing and uses pre-pop occupancy, so a pop in the same cycle never makes room
  always_comb begin
    space    = CNT_W'(DEPTH) - count;
    accept   = (n != '0) && (space >= n);
    drop     = (n != '0) && !accept;
    n_acc    = accept ? n : '0;
    pop      = out_valid && out_ready;
    drop_sum = {1'b0, drop_cnt} + 17'(n);
  end

  // Pointers, occupancy, sequence counter and sticky drop status; trace_clr takes priority over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (trace_clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wptr    <= wptr + AW'(n_acc);
      if (pop) rptr <= rptr + 1'b1;
      count   <= count + n_acc - CNT_W'(pop);
      // The sequence counter also advances on a drop, which leaves a visible gap downstream
      seq_cnt <= seq_cnt + 32'(n);
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  // Entry storage; it is not reset, because occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (!trace_clr && accept) begin
      for (int i = 0; i < CW; i++) begin
        if (cmt_valid[i]) mem[wr_idx[i]] <= lane_ent[i];
      end
    end
  end

  assign head          = mem[rptr];
  assign out_valid     = (count != '0);
  assign out_pc        = head.pc;
  assign out_insn      = head.insn;
  assign out_wen       = head.wen;
  assign out_wnum      = head.wnum;
  assign out_wdata     = head.wdata;
  assign out_excp      = head.excp;
  assign out_excp_vect = head.excp_vect;
  assign out_seq       = head.seq;

endmodule

// File: tb/tb_difftest_commit_serializer.sv
// Directed bench for difftest_commit_serializer with the default parameters
// (2 lanes, 8-entry FIFO).
module tb_difftest_commit_serializer;

  localparam int CW   = 2;
  localparam int PC_W = 30;
  localparam int IDW  = 32;
  localparam int LAW  = 5;
  localparam int DW   = 32;

  logic              clk;
  logic              rst_n;
  logic              trace_clr;
  logic [CW-1:0]     cmt_valid;
  logic [PC_W*CW-1:0] cmt_pc;
  logic [IDW*CW-1:0] cmt_insn;
  logic [CW-1:0]     cmt_wen;
  logic [LAW*CW-1:0] cmt_wnum;
  logic [DW*CW-1:0]  cmt_wdata;
  logic [CW-1:0]     cmt_excp;
  logic [32*CW-1:0]  cmt_excp_vect;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [IDW-1:0]    out_insn;
  logic              out_wen;
  logic [LAW-1:0]    out_wnum;
  logic [DW-1:0]     out_wdata;
  logic              out_excp;
  logic [31:0]       out_excp_vect;
  logic [31:0]       out_seq;
  logic              overflow;
  logic [15:0]       drop_cnt;

  int vectors = 0;
  int errors  = 0;

  difftest_commit_serializer dut (
    .clk(clk), .rst_n(rst_n), .trace_clr(trace_clr),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_insn(cmt_insn),
    .cmt_wen(cmt_wen), .cmt_wnum(cmt_wnum), .cmt_wdata(cmt_wdata),
    .cmt_excp(cmt_excp), .cmt_excp_vect(cmt_excp_vect),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen),
    .out_wnum(out_wnum), .out_wdata(out_wdata), .out_excp(out_excp),
    .out_excp_vect(out_excp_vect), .out_seq(out_seq),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so sampling is away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: load one lane's fields
  task automatic set_lane(input int i, input logic [PC_W-1:0] pc, input logic wen,
                          input logic [LAW-1:0] wnum, input logic [DW-1:0] wdata,
                          input logic excp, input logic [31:0] vect);
    cmt_pc[i*PC_W +: PC_W]  = pc;
    cmt_insn[i*IDW +: IDW]  = {2'b00, pc} ^ 32'h0000_0013;
    cmt_wen[i]              = wen;
    cmt_wnum[i*LAW +: LAW]  = wnum;
    cmt_wdata[i*DW +: DW]   = wdata;
    cmt_excp[i]             = excp;
    cmt_excp_vect[i*32 +: 32] = vect;
  endtask

  task automatic set_pair(input logic [PC_W-1:0] pc0);
    set_lane(0, pc0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    set_lane(1, pc0 + 30'd1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_clr();
    trace_clr = 1'b1;
    step();
    trace_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trace_clr = 1'b0; out_ready = 1'b0;
    cmt_valid = '0; cmt_pc = '0; cmt_insn = '0; cmt_wen = '0;
    cmt_wnum = '0; cmt_wdata = '0; cmt_excp = '0; cmt_excp_vect = '0;
    step(); step();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    #2 rst_n = 1'b1;
    step();

    // Two-lane packet, drained back to back
    set_pair(30'h100);
    cmt_valid = 2'b11; out_ready = 1'b1;
    step();
    cmt_valid = 2'b00;
    chk("t1_valid0", 64'(out_valid), 64'd1);
    chk("t1_pc0", 64'(out_pc), 64'h100);
    chk("t1_insn0", 64'(out_insn), 64'h113);
    chk("t1_seq0", 64'(out_seq), 64'd0);
    step();
    chk("t1_pc1", 64'(out_pc), 64'h101);
    chk("t1_seq1", 64'(out_seq), 64'd1);
    step();
    chk("t1_empty", 64'(out_valid), 64'd0);

    // Lane 0 idle, so lane 1 is compacted into the head slot
    do_clr();
    set_lane(0, 30'h1FF, 1'b0, 5'd9, 32'h1111_1111, 1'b0, 32'h0);
    set_lane(1, 30'h200, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 32'h0000_0008);
    cmt_valid = 2'b10;
    step();
    cmt_valid = 2'b00;
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_pc", 64'(out_pc), 64'h200);
    chk("t2_wen", 64'(out_wen), 64'd1);
    chk("t2_wnum", 64'(out_wnum), 64'd3);
    chk("t2_wdata", 64'(out_wdata), 64'hDEAD_BEEF);
    chk("t2_excp", 64'(out_excp), 64'd1);
    chk("t2_vect", 64'(out_excp_vect), 64'h8);
    chk("t2_seq", 64'(out_seq), 64'd0);
    step();
    chk("t2_empty", 64'(out_valid), 64'd0);

    // Fill to 8 entries, then overflow on the fifth packet
    do_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_pair(30'h300 + 30'(2*k));
      cmt_valid = 2'b11;
      step();
    end
    chk("t3_full_pc", 64'(out_pc), 64'h300);
    chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
    set_pair(30'h3F0);
    step();
    cmt_valid = 2'b00;
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t3_head_held", 64'(out_seq), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_drain_seq%0d", i), 64'(out_seq), 64'(i));
      chk($sformatf("t3_drain_pc%0d", i), 64'(out_pc), 64'(30'h300 + 30'(i)));
      step();
    end
    chk("t3_drained", 64'(out_valid), 64'd0);
    set_pair(30'h380);
    cmt_valid = 2'b11;
    step();
    cmt_valid = 2'b00;
    chk("t3_seq_after_gap", 64'(out_seq), 64'd10);
    step();
    chk("t3_seq_next", 64'(out_seq), 64'd11);
    step();
    chk("t3_empty", 64'(out_valid), 64'd0);

    // count = 7: a 2-lane push alongside a pop is still rejected
    do_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_pair(30'h400 + 30'(2*k));
      cmt_valid = 2'b11;
      step();
    end
    set_lane(1, 30'h406, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    cmt_valid = 2'b10;
    step();
    set_pair(30'h4F0);
    cmt_valid = 2'b11; out_ready = 1'b1;
    step();
    cmt_valid = 2'b00;
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 1; i < 7; i++) begin
      chk($sformatf("t4_seq%0d", i), 64'(out_seq), 64'(i));
      step();
    end
    chk("t4_count6_empty", 64'(out_valid), 64'd0);

    // trace_clr with 5 queued entries and a colliding packet
    do_clr();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_pair(30'h480 + 30'(2*k));
      cmt_valid = 2'b11;
      step();
    end
    cmt_valid = 2'b00; out_ready = 1'b1;
    step(); step(); step();
    chk("t5_pre_seq", 64'(out_seq), 64'd3);
    chk("t5_pre_ovf", 64'(overflow), 64'd1);
    trace_clr = 1'b1; cmt_valid = 2'b11;
    step();
    trace_clr = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    set_pair(30'h500);
    step();
    cmt_valid = 2'b00;
    chk("t5_pc", 64'(out_pc), 64'h500);
    chk("t5_seq", 64'(out_seq), 64'd0);
    step();
    chk("t5_seq1", 64'(out_seq), 64'd1);
    step();
    chk("t5_empty", 64'(out_valid), 64'd0);

    // 20 two-lane packets, one every other cycle, with out_ready held high
    do_clr();
    out_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      set_pair(30'h600 + 30'(2*p));
      cmt_valid = 2'b11;
      step();
      cmt_valid = 2'b00;
      chk($sformatf("t6_seq%0d", 2*p), 64'(out_seq), 64'(2*p));
      chk($sformatf("t6_pc%0d", 2*p), 64'(out_pc), 64'(30'h600 + 30'(2*p)));
      step();
      chk($sformatf("t6_seq%0d", 2*p+1), 64'(out_seq), 64'(2*p+1));
      chk($sformatf("t6_pc%0d", 2*p+1), 64'(out_pc), 64'(30'h601 + 30'(2*p)));
    end
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_no_ovf", 64'(overflow), 64'd0);
    chk("t6_no_drop", 64'(drop_cnt), 64'd0);
    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 64'(out_valid), 64'd0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
